// File: rtl/rvc_fetch_aligner.sv
// RV32C fetch aligner: halfword queue, instruction reassembly and
// compressed-to-32-bit expansion with a valid/ready output register.
module rvc_fetch_aligner #(
  parameter int unsigned FETCH_W  = 32,
  parameter int unsigned BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [FETCH_W-1:0] fetch_data,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  output logic               ins_valid,
  input  logic               ins_ready,
  output logic [31:0]        ins_o,
  output logic [31:0]        ins_pc,
  output logic               ins_is_c,
  output logic [15:0]        ins_raw16,
  output logic               ins_illegal
);

  localparam int unsigned NH   = FETCH_W / 16;
  localparam int unsigned PW   = $clog2(BUF_HW);
  localparam int unsigned CW   = $clog2(BUF_HW + 1);
  localparam int unsigned OFFB = $clog2(FETCH_W / 8);
  localparam int unsigned SKW  = OFFB - 1;

  localparam logic [CW-1:0] NH_C  = CW'(NH);
  localparam logic [CW-1:0] BUF_C = CW'(BUF_HW);

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] JAL    = 7'h6f;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] BRANCH = 7'h63;

  typedef struct packed {
    logic [31:0] ins;
    logic        ill;
  } exp_t;

  logic [15:0]    q [BUF_HW];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;
  logic [SKW-1:0] skip;
  logic [31:0]    pc_head;

  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          is32;
  logic [CW-1:0] need;
  logic [CW-1:0] push_n;
  logic [CW-1:0] push_amt;
  logic [CW-1:0] pop_n;
  logic          do_pop;
  logic          do_push;
  exp_t          ex;
  logic          unused_pc0;

  assign unused_pc0 = flush_pc[0];

  function automatic logic [PW-1:0] wrap(input int unsigned idx);
    return PW'(idx >= BUF_HW ? idx - BUF_HW : idx);
  endfunction

  function automatic exp_t expand(input logic [15:0] c);
    exp_t        r;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rp_hi;
    logic [4:0]  rp_lo;
    logic [11:0] i6;
    logic [11:0] imm;
    logic [20:1] j;
    logic [12:1] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    r.ins = 32'h0;
    r.ill = 1'b0;
    rd    = c[11:7];
    rs2   = c[6:2];
    rp_hi = {2'b01, c[9:7]};
    rp_lo = {2'b01, c[4:2]};
    i6    = {{6{c[12]}}, c[12], c[6:2]};
    j     = {{10{c[12]}}, c[8], c[10:9], c[6], c[7],
             c[2], c[11], c[5:3]};
    b     = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3]};
    imm   = 12'h0;
    f3    = 3'b000;
    f7    = 7'b0000000;
    unique case (1'b1)
      c[1:0] == 2'b00: begin
        case (c[15:13])
          3'b000: begin
            imm = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
            r.ins = {imm, 5'd2, 3'b000, rp_lo, OP_IMM};
            r.ill = (imm == 12'h0);
          end
          3'b010: begin
            imm = {5'b0, c[5], c[12:10], c[6], 2'b00};
            r.ins = {imm, rp_hi, 3'b010, rp_lo, LOAD};
          end
          3'b110: begin
            imm = {5'b0, c[5], c[12:10], c[6], 2'b00};
            r.ins = {imm[11:5], rp_lo, rp_hi, 3'b010, imm[4:0], STORE};
          end
          default: r.ill = 1'b1;
        endcase
      end
      c[1:0] == 2'b01: begin
        case (c[15:13])
          3'b000: r.ins = {i6, rd, 3'b000, rd, OP_IMM};
          3'b001: r.ins = {j[20], j[10:1], j[11], j[19:12], 5'd1, JAL};
          3'b010: r.ins = {i6, 5'd0, 3'b000, rd, OP_IMM};
          3'b011: begin
            if (rd == 5'd2) begin
              imm = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0};
              r.ins = {imm, 5'd2, 3'b000, 5'd2, OP_IMM};
              r.ill = (imm == 12'h0);
            end else begin
              r.ins = {{14{c[12]}}, c[12], c[6:2], rd, LUI};
              r.ill = ({c[12], c[6:2]} == 6'h0);
            end
          end
          3'b100: begin
            case (c[11:10])
              2'b00: begin
                r.ins = {7'b0, c[6:2], rp_hi, 3'b101, rp_hi, OP_IMM};
                r.ill = c[12];
              end
              2'b01: begin
                r.ins = {7'b0100000, c[6:2], rp_hi, 3'b101, rp_hi, OP_IMM};
                r.ill = c[12];
              end
              2'b10: r.ins = {i6, rp_hi, 3'b111, rp_hi, OP_IMM};
              default: begin
                case (c[6:5])
                  2'b00: begin f3 = 3'b000; f7 = 7'b0100000; end
                  2'b01: f3 = 3'b100;
                  2'b10: f3 = 3'b110;
                  default: f3 = 3'b111;
                endcase
                r.ins = {f7, rp_lo, rp_hi, f3, rp_hi, OP};
                r.ill = c[12];
              end
            endcase
          end
          3'b101: r.ins = {j[20], j[10:1], j[11], j[19:12], 5'd0, JAL};
          3'b110: r.ins = {b[12], b[10:5], 5'd0, rp_hi, 3'b000,
                           b[4:1], b[11], BRANCH};
          default: r.ins = {b[12], b[10:5], 5'd0, rp_hi, 3'b001,
                            b[4:1], b[11], BRANCH};
        endcase
      end
      c[1:0] == 2'b10: begin
        case (c[15:13])
          3'b000: begin
            r.ins = {7'b0, c[6:2], rd, 3'b001, rd, OP_IMM};
            r.ill = c[12];
          end
          3'b010: begin
            imm = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
            r.ins = {imm, 5'd2, 3'b010, rd, LOAD};
            r.ill = (rd == 5'd0);
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == 5'd0) begin
                r.ins = {12'h0, rd, 3'b000, 5'd0, JALR};
                r.ill = (rd == 5'd0);
              end else begin
                r.ins = {7'b0, rs2, 5'd0, 3'b000, rd, OP};
              end
            end else if (rs2 == 5'd0) begin
              if (rd == 5'd0) r.ins = 32'h00100073;
              else r.ins = {12'h0, rd, 3'b000, 5'd1, JALR};
            end else begin
              r.ins = {7'b0, rs2, rd, 3'b000, rd, OP};
            end
          end
          3'b110: begin
            imm = {4'b0, c[8:7], c[12:9], 2'b00};
            r.ins = {imm[11:5], rs2, 5'd2, 3'b010, imm[4:0], STORE};
          end
          default: r.ill = 1'b1;
        endcase
      end
      default: r.ill = 1'b1;
    endcase
    // Illegal halfwords pass through raw for the trap handler
    if (r.ill) r.ins = {16'h0, c};
    return r;
  endfunction

  always_comb begin
    h0       = q[head];
    h1       = q[wrap(int'(head) + 1)];
    is32     = (h0[1:0] == 2'b11);
    need     = is32 ? CW'(2) : CW'(1);
    ex       = expand(h0);
    do_pop   = !flush && (!ins_valid || ins_ready) && (count >= need);
    pop_n    = do_pop ? need : CW'(0);
    push_n   = NH_C - CW'(skip);
    push_amt = do_push ? push_n : CW'(0);
  end

  assign fetch_ready = !flush && ((BUF_C - count) >= NH_C);
  assign do_push     = fetch_valid && fetch_ready;

  // Leading halfwords below a redirect target are dropped on entry
  always_ff @(posedge clk) begin
    if (do_push) begin
      for (int i = 0; i < NH; i++) begin
        if (i >= int'(skip))
          q[wrap(int'(tail) + i - int'(skip))] <= fetch_data[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      skip        <= RESET_PC[OFFB-1:1];
      pc_head     <= {RESET_PC[31:1], 1'b0};
      ins_valid   <= 1'b0;
      ins_o       <= 32'h0;
      ins_pc      <= RESET_PC;
      ins_is_c    <= 1'b0;
      ins_raw16   <= 16'h0;
      ins_illegal <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      skip      <= flush_pc[OFFB-1:1];
      pc_head   <= {flush_pc[31:1], 1'b0};
      ins_valid <= 1'b0;
    end else begin
      if (do_push) begin
        tail <= wrap(int'(tail) + int'(push_n));
        skip <= '0;
      end
      if (do_pop) begin
        head        <= wrap(int'(head) + int'(need));
        pc_head     <= pc_head + (is32 ? 32'd4 : 32'd2);
        ins_valid   <= 1'b1;
        ins_pc      <= pc_head;
        ins_is_c    <= !is32;
        ins_raw16   <= is32 ? 16'h0 : h0;
        ins_illegal <= !is32 && ex.ill;
        ins_o       <= is32 ? {h1, h0} : ex.ins;
      end else if (ins_ready) begin
        ins_valid <= 1'b0;
      end
      count <= count + push_amt - pop_n;
    end
  end

endmodule

// File: doc/rvc_fetch_aligner.md
# rvc_fetch_aligner

Parametrised RV32C fetch aligner and expander, placed between the instruction-memory fetch stage and the decode stage of the pipeline. It accepts fetch words of `FETCH_W` bits into a halfword queue and reassembles 16-bit and 32-bit instructions, including 32-bit instructions that straddle fetch words. It expands every 16-bit instruction to its 32-bit equivalent and emits one instruction per cycle, with its PC, over a valid/ready handshake. It supports pipeline flush/redirect to any halfword-aligned PC.

## Interface
- `FETCH_W`, 32: fetch word width; legal values are 32 and 64. `NH = FETCH_W/16` halfwords per fetch word.
- `BUF_HW`, 4: halfword queue depth. Must satisfy `BUF_HW >= NH+1`.
- `RESET_PC`, 32'h0: PC of the first instruction after reset.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `fetch_valid`  in  1  fetch word present.
- `fetch_ready`  out  1  aligner can accept a full fetch word this cycle.
- `fetch_data`  in  FETCH_W  fetch word; halfword 0 is in bits [15:0] (lowest address).
- `flush`  in  1  redirect; discard all buffered and pending instructions.
- `flush_pc`  in  32  redirect target; bit 0 is ignored.
- `ins_valid`  out  1  output instruction valid.
- `ins_ready`  in  1  decode accepts the output instruction.
- `ins_o`  out  32  expanded (or native) 32-bit instruction.
- `ins_pc`  out  32  PC of `ins_o`.
- `ins_is_c`  out  1  source instruction was 16-bit.
- `ins_raw16`  out  16  original halfword when `ins_is_c`=1, else 0.
- `ins_illegal`  out  1  16-bit encoding is illegal or reserved; `ins_o` then carries the raw halfword zero-extended.

## Operation
- **Queue.** Circular buffer of `BUF_HW` halfwords with head/tail pointers and count (`$clog2(BUF_HW+1)` bits). Pointers wrap modulo `BUF_HW`.
- **Fetch handshake.** `fetch_ready = !flush && (BUF_HW - count) >= NH`. A push occurs on `fetch_valid && fetch_ready` and writes all NH halfwords, minus any skipped halfwords (below).
- **Halfword skip.** After a flush, the first accepted word drops its leading `flush_pc[$clog2(FETCH_W/8)-1:1]` halfwords. After reset the skip is `RESET_PC`'s offset.
- **Instruction length.** The head halfword's bits [1:0] decide length: `!=2'b11` is a 16-bit instruction needing 1 halfword; `==2'b11` is a 32-bit instruction needing 2 halfwords (head, head+1).
- **Pop.** A pop occurs when the output register is empty or `ins_ready`=1, and the queue holds the required halfwords.
  - The pop loads the output register and advances head by 1 or 2.
  - Push and pop in the same cycle are legal; count updates by the net amount.
- **PC tracking.** `pc_head` starts at `RESET_PC` (or `flush_pc` with bit 0 cleared) and advances by 2 or 4 on each pop.
- **Expander (combinational, before the output register).** Covers the full RV32C integer set:
  - Q0: C.ADDI4SPN, C.LW, C.SW.
  - Q1: C.NOP/C.ADDI, C.JAL, C.LI, C.ADDI16SP/C.LUI, C.SRLI/C.SRAI/C.ANDI, C.SUB/C.XOR/C.OR/C.AND, C.J, C.BEQZ, C.BNEZ.
  - Q2: C.SLLI, C.LWSP, C.JR/C.MV/C.EBREAK/C.JALR/C.ADD, C.SWSP.
  - Immediates are sign- or zero-extended per the RVC spec. rd'/rs' map to x8–x15.
- **Illegal encodings.** The following raise `ins_illegal`:
  - 16'h0000;
  - C.ADDI4SPN with imm=0;
  - C.LWSP with rd=0;
  - C.JR with rs1=0;
  - C.LUI/C.ADDI16SP with imm=0;
  - RV32 shifts with shamt[5]=1;
  - floating-point and RV64 slots.
- **Flush.**
  - On the flush cycle: count, head and tail clear; `ins_valid` goes to 0 next edge; `pc_head <= {flush_pc[31:1],1'b0}`; the skip is recomputed.
  - A fetch word presented in the flush cycle is not accepted.
  - Flush has priority over pop and push.

## Timing
- **Reset values:** `ins_valid`=0, `ins_o`=0, `ins_pc`=`RESET_PC`, `ins_is_c`=0, `ins_raw16`=0, `ins_illegal`=0, count=0, `fetch_ready`=1 after release.
- **Latency:** fetch word accepted at edge N → first instruction visible after edge N+1. A 32-bit instruction straddling words appears one edge after its second word is accepted.
- **Output hold:** `ins_*` is held stable while `ins_valid && !ins_ready`.
- **Throughput:** one instruction per cycle with `ins_ready` high.
- **Mid-operation reset:** asynchronous clear to the reset values above. There is no partial output.

## Test plan
- **Expansion check** (FETCH_W=32): feed word 32'h00850001 at PC 0 → outputs 32'h00000013 (pc 0, is_c=1), then 32'h00108093 (pc 2, raw16 16'h0085).
- **Straddling 32-bit instruction:** feed words 32'h00930001, then 32'h00010050 → outputs 32'h00000013 @0, 32'h00500093 @2 (is_c=0), 32'h00000013 @6.
- **Other expansions:** 16'h952E → 32'h00B50533; 16'hA011 → 32'h0040006F; 16'h4080 → 32'h0004A403; 16'h0000 → `ins_illegal`=1, `ins_o`=0.
- **Back-pressure:** hold `ins_ready`=0 for 5 cycles with `fetch_valid`=1 and a stream of 16-bit instructions. Required: `ins_*` stable, `fetch_ready` drops to 0 at count>BUF_HW-NH, no halfword lost or duplicated after release.
- **Flush to 32'h0000_0102:** pulse flush during traffic → no `ins_valid` in the next cycle; the next accepted word drops halfword 0; the first output has pc 32'h102 and holds bits [31:16] of that word.
- **FETCH_W=64, BUF_HW=6:** four C.NOPs per word at full rate → 4 outputs per word, pcs incrementing by 2. Assert `rst` mid-stream → all outputs return to their reset values immediately.
